qspi_cmd_receiver: RTL and testbench

QSPI_CMD_RECEIVER -- requirements
Module: qspi_cmd_receiver

---
 rtl/qspi_pkg.sv | 86 ++++++++
 rtl/qspi_lane_shifter.sv | 64 ++++++
 rtl/qspi_cmd_receiver.sv | 232 +++++++++++++++++++++++
 tb/tb_qspi_cmd_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types for the QSPI command receiver: command types, opcodes, lane modes and FSM states.
// The cmd_type encoding is also used by the sequence generator, so keep it stable.
package qspi_pkg;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    CMD_READ          = 3'd0,
    CMD_WRITE         = 3'd1,
    CMD_READ_STATUS   = 3'd2,
    CMD_WRITE_STATUS  = 3'd3,
    CMD_READ_ID       = 3'd4,
    CMD_WRITE_ENABLE  = 3'd5,
    CMD_WRITE_DISABLE = 3'd6,
    CMD_ERASE         = 3'd7
  } cmd_type_e;

  localparam logic [7:0] OP_READ          = 8'h03;
  localparam logic [7:0] OP_WRITE         = 8'h02;
  localparam logic [7:0] OP_READ_STATUS   = 8'h05;
  localparam logic [7:0] OP_WRITE_STATUS  = 8'h01;
  localparam logic [7:0] OP_READ_ID       = 8'h9F;
  localparam logic [7:0] OP_WRITE_ENABLE  = 8'h06;
  localparam logic [7:0] OP_WRITE_DISABLE = 8'h04;
  localparam logic [7:0] OP_ERASE         = 8'h20;

  typedef enum logic [1:0] {
    XSPI_SINGLE = 2'b00,
    XSPI_DUAL   = 2'b01,
    XSPI_QUAD   = 2'b10,
    XSPI_RSVD   = 2'b11
  } xspi_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE,
    ST_IGNORE
  } state_e;

  typedef struct packed {
    logic      valid;
    cmd_type_e cmd;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [7:0] op);
    op_dec_t d;
    d.valid = 1'b1;
    d.cmd   = CMD_READ;
    case (op)
      OP_READ:          d.cmd = CMD_READ;
      OP_WRITE:         d.cmd = CMD_WRITE;
      OP_READ_STATUS:   d.cmd = CMD_READ_STATUS;
      OP_WRITE_STATUS:  d.cmd = CMD_WRITE_STATUS;
      OP_READ_ID:       d.cmd = CMD_READ_ID;
      OP_WRITE_ENABLE:  d.cmd = CMD_WRITE_ENABLE;
      OP_WRITE_DISABLE: d.cmd = CMD_WRITE_DISABLE;
      OP_ERASE:         d.cmd = CMD_ERASE;
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Reserved lane mode behaves as single.
  function automatic logic [CNT_W-1:0] bits_per_edge(input xspi_e m);
    case (m)
      XSPI_DUAL: bits_per_edge = CNT_W'(2);
      XSPI_QUAD: bits_per_edge = CNT_W'(4);
      default:   bits_per_edge = CNT_W'(1);
    endcase
  endfunction

  function automatic logic [3:0] oe_mask(input xspi_e m);
    case (m)
      XSPI_DUAL: oe_mask = 4'b0011;
      XSPI_QUAD: oe_mask = 4'b1111;
      default:   oe_mask = 4'b0010;
    endcase
  endfunction

endpackage

// File: rtl/qspi_lane_shifter.sv
// 1/2/4-lane MSB-first shift register: shifts serial lanes in, or loads a word and shifts it out.
// Higher lane numbers carry the more significant bit of each group.
module qspi_lane_shifter
  import qspi_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             shift_in_i,
  input  logic             shift_out_i,
  input  logic             load_i,
  input  xspi_e            mode_i,
  input  logic [3:0]       io_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] data_next_c,
  output logic [3:0]       io_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shout_c;

  // Output lanes always present the top bits of the word being transmitted.
  function automatic logic [3:0] lane_msbs(input logic [WIDTH-1:0] v, input xspi_e m);
    case (m)
      XSPI_DUAL: lane_msbs = {2'b00, v[WIDTH-1 -: 2]};
      XSPI_QUAD: lane_msbs = v[WIDTH-1 -: 4];
      default:   lane_msbs = {2'b00, v[WIDTH-1], 1'b0};
    endcase
  endfunction

  always_comb begin
    data_next_c = {data_q[WIDTH-2:0], io_i[0]};
    shout_c     = {data_q[WIDTH-2:0], 1'b0};
    case (mode_i)
      XSPI_DUAL: begin
        data_next_c = {data_q[WIDTH-3:0], io_i[1:0]};
        shout_c     = {data_q[WIDTH-3:0], 2'b00};
      end
      XSPI_QUAD: begin
        data_next_c = {data_q[WIDTH-5:0], io_i};
        shout_c     = {data_q[WIDTH-5:0], 4'b0000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      data_q <= '0;
      io_o   <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
      io_o   <= lane_msbs(load_data_i, mode_i);
    end else if (shift_out_i) begin
      data_q <= shout_c;
      io_o   <= lane_msbs(shout_c, mode_i);
    end else if (shift_in_i) begin
      data_q <= data_next_c;
    end
  end

endmodule

// File: rtl/qspi_cmd_receiver.sv
// QSPI target-side command receiver: oversamples sclk_i on clk_i, decodes opcode/address/data
// and shifts read data out; reports completed frames and aborts as single-cycle pulses.
module qspi_cmd_receiver
  import qspi_pkg::*;
#(
  parameter int unsigned SCLK_MIN_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_n_i,
  input  logic        sclk_i,
  input  logic [3:0]  io_i,
  input  logic [1:0]  xspi_i,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe_o,
  output logic [2:0]  cmd_type_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        frame_valid_o,
  output logic        abort_o,
  output logic        rdata_req_o,
  input  logic [31:0] rdata_i
);

  // A registered rdata_i responder needs a full clk between request and the next sclk fall.
  if (SCLK_MIN_DIV < 4) begin : g_div_check
    $error("qspi_cmd_receiver: SCLK_MIN_DIV must be at least 4");
  end

  state_e           state_q, state_d;
  xspi_e            mode_q, mode_d;
  cmd_type_e        cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [31:0]      addr_q, addr_d;
  logic             tx_loaded_q, tx_loaded_d;
  logic             sclk_q, sclk_rise, sclk_fall;

  logic [2:0]       cmd_type_d;
  logic [31:0]      addr_out_d, wdata_out_d;
  logic [3:0]       io_oe_d;
  logic             frame_valid_d, abort_d, rdata_req_d;

  logic             sh_clear, sh_in, sh_out, sh_load;
  logic [31:0]      sh_next;
  op_dec_t          dec;

  assign sclk_rise = sclk_i & ~sclk_q;
  assign sclk_fall = ~sclk_i & sclk_q;

  qspi_lane_shifter #(.WIDTH(WORD_BITS)) u_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (sh_clear),
    .shift_in_i  (sh_in),
    .shift_out_i (sh_out),
    .load_i      (sh_load),
    .mode_i      (mode_q),
    .io_i        (io_i),
    .load_data_i (rdata_i),
    .data_next_c (sh_next),
    .io_o        (io_o)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    tx_loaded_d   = tx_loaded_q;
    cmd_type_d    = cmd_type_o;
    addr_out_d    = addr_o;
    wdata_out_d   = wdata_o;
    frame_valid_d = 1'b0;
    abort_d       = 1'b0;
    rdata_req_d   = 1'b0;
    sh_clear      = 1'b0;
    sh_in         = 1'b0;
    sh_out        = 1'b0;
    sh_load       = 1'b0;
    cnt_next      = cnt_q + bits_per_edge(mode_q);
    dec           = decode_op(sh_next[7:0]);

    // Losing chip select mid-frame beats any coincident sclk edge.
    if (cs_n_i && (state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA})) begin
      abort_d = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sh_clear    = 1'b1;
          cnt_d       = '0;
          tx_loaded_d = 1'b0;
          if (!cs_n_i) begin
            state_d = ST_CMD;
            mode_d  = xspi_e'(xspi_i);
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            sh_in = 1'b1;
            cnt_d = cnt_next;
            if (cnt_next == CNT_W'(CMD_BITS)) begin
              cnt_d = '0;
              if (!dec.valid) begin
                state_d = ST_IGNORE;
                abort_d = 1'b1;
              end else begin
                cmd_d = dec.cmd;
                case (dec.cmd)
                  CMD_READ, CMD_WRITE, CMD_ERASE: state_d = ST_ADDR;
                  CMD_WRITE_STATUS:               state_d = ST_WDATA;
                  CMD_READ_STATUS, CMD_READ_ID: begin
                    state_d     = ST_RDATA;
                    rdata_req_d = 1'b1;
                    tx_loaded_d = 1'b0;
                  end
                  default: begin
                    state_d       = ST_DONE;
                    frame_valid_d = 1'b1;
                    cmd_type_d    = dec.cmd;
                  end
                endcase
              end
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            sh_in = 1'b1;
            cnt_d = cnt_next;
            if (cnt_next == CNT_W'(WORD_BITS)) begin
              cnt_d  = '0;
              addr_d = sh_next;
              case (cmd_q)
                CMD_READ: begin
                  state_d     = ST_RDATA;
                  rdata_req_d = 1'b1;
                  tx_loaded_d = 1'b0;
                end
                CMD_WRITE: state_d = ST_WDATA;
                default: begin
                  state_d       = ST_DONE;
                  frame_valid_d = 1'b1;
                  cmd_type_d    = cmd_q;
                  addr_out_d    = sh_next;
                end
              endcase
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            sh_in = 1'b1;
            cnt_d = cnt_next;
            if (cnt_next == CNT_W'(WORD_BITS)) begin
              cnt_d         = '0;
              state_d       = ST_DONE;
              frame_valid_d = 1'b1;
              cmd_type_d    = cmd_q;
              wdata_out_d   = sh_next;
              if (cmd_q == CMD_WRITE) addr_out_d = addr_q;
            end
          end
        end
        ST_RDATA: begin
          // First fall after the request loads rdata_i; later falls advance the shifter.
          if (sclk_fall) begin
            if (!tx_loaded_q) begin
              sh_load     = 1'b1;
              tx_loaded_d = 1'b1;
            end else begin
              sh_out = 1'b1;
            end
          end
          if (sclk_rise) begin
            cnt_d = cnt_next;
            if (cnt_next == CNT_W'(WORD_BITS)) begin
              cnt_d         = '0;
              state_d       = ST_DONE;
              frame_valid_d = 1'b1;
              cmd_type_d    = cmd_q;
              if (cmd_q == CMD_READ) addr_out_d = addr_q;
            end
          end
        end
        ST_DONE, ST_IGNORE: begin
          if (cs_n_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    io_oe_d = (state_d == ST_RDATA) ? oe_mask(mode_q) : 4'b0000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mode_q        <= XSPI_SINGLE;
      cmd_q         <= CMD_READ;
      cnt_q         <= '0;
      addr_q        <= '0;
      tx_loaded_q   <= 1'b0;
      sclk_q        <= 1'b0;
      cmd_type_o    <= '0;
      addr_o        <= '0;
      wdata_o       <= '0;
      io_oe_o       <= '0;
      frame_valid_o <= 1'b0;
      abort_o       <= 1'b0;
      rdata_req_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      tx_loaded_q   <= tx_loaded_d;
      sclk_q        <= sclk_i;
      cmd_type_o    <= cmd_type_d;
      addr_o        <= addr_out_d;
      wdata_o       <= wdata_out_d;
      io_oe_o       <= io_oe_d;
      frame_valid_o <= frame_valid_d;
      abort_o       <= abort_d;
      rdata_req_o   <= rdata_req_d;
    end
  end

endmodule

// File: tb/tb_qspi_cmd_receiver.sv
// Scoreboard bench for qspi_cmd_receiver: a bit-level SPI master drives frames, a frame-level
// model predicts completion/abort events and held outputs, and a monitor checks each event.
module tb_qspi_cmd_receiver;
  import qspi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, cs_n_i, sclk_i;
  logic [3:0]  io_i;
  logic [1:0]  xspi_i;
  logic [31:0] rdata_i;
  logic [3:0]  io_o, io_oe_o;
  logic [2:0]  cmd_type_o;
  logic [31:0] addr_o, wdata_o;
  logic        frame_valid_o, abort_o, rdata_req_o;

  typedef struct {
    bit          is_abort;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rreq_seen = 0;
  int          rreq_exp = 0;
  logic [2:0]  ref_cmd = '0;
  logic [31:0] ref_addr = '0;
  logic [31:0] ref_wdata = '0;
  logic [7:0]  known_ops [8] = '{8'h03, 8'h02, 8'h05, 8'h01, 8'h9F, 8'h06, 8'h04, 8'h20};

  always #5 clk_i = ~clk_i;

  qspi_cmd_receiver #(.SCLK_MIN_DIV(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cs_n_i        (cs_n_i),
    .sclk_i        (sclk_i),
    .io_i          (io_i),
    .xspi_i        (xspi_i),
    .io_o          (io_o),
    .io_oe_o       (io_oe_o),
    .cmd_type_o    (cmd_type_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .frame_valid_o (frame_valid_o),
    .abort_o       (abort_o),
    .rdata_req_o   (rdata_req_o),
    .rdata_i       (rdata_i)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Opcode table: command type and which phases the frame carries.
  function automatic bit model_decode(input logic [7:0] op, output logic [2:0] ct,
                                      output bit ha, output bit hw, output bit hr);
    ct = 3'd0; ha = 1'b0; hw = 1'b0; hr = 1'b0;
    case (op)
      8'h03: begin ct = 3'(CMD_READ);          ha = 1'b1; hr = 1'b1; end
      8'h02: begin ct = 3'(CMD_WRITE);         ha = 1'b1; hw = 1'b1; end
      8'h05: begin ct = 3'(CMD_READ_STATUS);   hr = 1'b1; end
      8'h01: begin ct = 3'(CMD_WRITE_STATUS);  hw = 1'b1; end
      8'h9F: begin ct = 3'(CMD_READ_ID);       hr = 1'b1; end
      8'h06: ct = 3'(CMD_WRITE_ENABLE);
      8'h04: ct = 3'(CMD_WRITE_DISABLE);
      8'h20: begin ct = 3'(CMD_ERASE);         ha = 1'b1; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Monitor: every frame_valid_o / abort_o pulse must match the oldest expected event.
  always @(negedge clk_i) begin
    exp_t e;
    if (rdata_req_o) rreq_seen++;
    if (frame_valid_o || abort_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", {30'd0, frame_valid_o, abort_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("event_abort", 32'(abort_o), 32'(e.is_abort));
        chk("event_valid", 32'(frame_valid_o), 32'(!e.is_abort));
        chk("cmd_type", 32'(cmd_type_o), 32'(e.cmd));
        chk("addr", addr_o, e.addr);
        chk("wdata", wdata_o, e.wdata);
      end
    end
  end

  // cut_edges < 0: full frame; rst_edge >= 0: reset after that many read-phase rises.
  task automatic run_frame(input logic [1:0] x, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int cut_edges, input int rst_edge);
    int          lanes, pre_bits, tot_bits, n_edges;
    bit          known, ha, hw, hr, complete;
    logic [2:0]  ct;
    bit          stream[$];
    logic [31:0] rx;
    logic [3:0]  oe_exp;
    exp_t        e;

    lanes = (x == 2'b01) ? 2 : (x == 2'b10) ? 4 : 1;
    oe_exp = (x == 2'b01) ? 4'b0011 : (x == 2'b10) ? 4'b1111 : 4'b0010;
    known = model_decode(op, ct, ha, hw, hr);
    for (int i = 7; i >= 0; i--) stream.push_back(op[i]);
    if (ha) for (int i = 31; i >= 0; i--) stream.push_back(addr[i]);
    if (hw) for (int i = 31; i >= 0; i--) stream.push_back(wdata[i]);
    if (!known) for (int i = 0; i < 8; i++) stream.push_back(1'($urandom));
    pre_bits = stream.size();
    tot_bits = pre_bits + ((known && hr) ? 32 : 0);
    n_edges = tot_bits / lanes;
    if (cut_edges >= 0 && cut_edges < n_edges) n_edges = cut_edges;
    complete = (n_edges == tot_bits / lanes);

    if (rst_edge < 0) begin
      e.is_abort = !(known && complete);
      if (!e.is_abort) begin
        ref_cmd = ct;
        if (ha) ref_addr = addr;
        if (hw) ref_wdata = wdata;
      end
      e.cmd = ref_cmd; e.addr = ref_addr; e.wdata = ref_wdata;
      sb_q.push_back(e);
    end
    if (known && hr && (n_edges * lanes >= pre_bits || rst_edge >= 0)) rreq_exp++;

    rdata_i = rdata;
    xspi_i = x;
    rx = '0;
    @(negedge clk_i);
    cs_n_i = 1'b0;
    sclk_i = 1'b0;
    for (int k = 0; k < n_edges; k++) begin
      int b = k * lanes;
      io_i = 4'($urandom);
      if (b < pre_bits) for (int j = 0; j < lanes; j++) io_i[lanes-1-j] = stream[b+j];
      repeat (2) @(negedge clk_i);
      if (k == 1) xspi_i = 2'($urandom_range(0, 3));
      if (rst_edge >= 0 && b >= pre_bits + rst_edge * lanes) begin
        rst_i = 1'b1;
        cs_n_i = 1'b1;
        @(negedge clk_i);
        chk("rst_oe", 32'(io_oe_o), 32'd0);
        chk("rst_cmd_type", 32'(cmd_type_o), 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        rst_i = 1'b0;
        ref_cmd = '0; ref_addr = '0; ref_wdata = '0;
        repeat (3) @(negedge clk_i);
        return;
      end
      chk("io_oe", 32'(io_oe_o), (known && hr && b >= pre_bits) ? 32'(oe_exp) : 32'd0);
      if (b >= pre_bits) begin
        case (lanes)
          2:       rx = {rx[29:0], io_o[1:0]};
          4:       rx = {rx[27:0], io_o};
          default: rx = {rx[30:0], io_o[1]};
        endcase
      end
      sclk_i = 1'b1;
      repeat (2) @(negedge clk_i);
      sclk_i = 1'b0;
    end
    repeat (2) @(negedge clk_i);
    cs_n_i = 1'b1;
    // An aborted frame also sees an sclk rise in the same cycle chip select drops.
    if (!complete) sclk_i = 1'b1;
    @(negedge clk_i);
    sclk_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("oe_idle", 32'(io_oe_o), 32'd0);
    if (known && hr && complete) chk("read_data", rx, rdata);
  endtask

  initial begin
    logic [7:0] op;
    rst_i = 1'b1; cs_n_i = 1'b1; sclk_i = 1'b0; io_i = '0; xspi_i = '0; rdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_io", 32'(io_o), 32'd0);
    chk("reset_oe", 32'(io_oe_o), 32'd0);
    chk("reset_cmd_type", 32'(cmd_type_o), 32'd0);
    chk("reset_addr", addr_o, 32'd0);
    chk("reset_wdata", wdata_o, 32'd0);
    chk("reset_pulses", {29'd0, frame_valid_o, abort_o, rdata_req_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_frame(2'b00, 8'h06, 32'h0, 32'h0, 32'h0, -1, -1);
    run_frame(2'b10, 8'h02, 32'h0001_2340, 32'hDEAD_BEEF, 32'h0, -1, -1);
    run_frame(2'b01, 8'h03, 32'h0000_0010, 32'h0, 32'hA5A5_0F0F, -1, -1);
    run_frame(2'b00, 8'hFF, 32'h0, 32'h0, 32'h0, -1, -1);
    run_frame(2'b10, 8'h02, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 6, -1);
    run_frame(2'b11, 8'h05, 32'h0, 32'h0, 32'h5A3C_C3A5, -1, -1);
    run_frame(2'b00, 8'h05, 32'h0, 32'h0, 32'hFFFF_0001, -1, 5);
    run_frame(2'b10, 8'h20, 32'hCAFE_0000, 32'h0, 32'h0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : known_ops[$urandom_range(0, 7)];
      run_frame(2'($urandom_range(0, 3)), op, $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 71)) : -1, -1);
    end

    repeat (5) @(negedge clk_i);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("rdata_req_count", 32'(rreq_seen), 32'(rreq_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
